// File: rtl/mips_multicycle_cpu.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_cpu
// Purpose  : Multi-cycle MIPS-subset core. A single datapath is shared across
//            the FETCH/DECODE/EXEC/MEM/WB states. Instruction memory, data
//            memory and the register file are held on-chip and return to known
//            fill values on reset. The host loads instructions and starts the
//            core. Architectural state is visible through a debug read port.
// Ports    : clk          - clock, rising edge
//            Reset        - asynchronous active-high reset
//            start        - begin execution at PC 0 (ignored while busy)
//            imem_we      - instruction-memory write strobe (ignored while busy)
//            imem_addr    - word index for the instruction write
//            imem_wdata   - instruction word to write
//            dbg_reg_addr - debug register select
//            dbg_reg_data - combinational register read (r0 reads 0)
//            pc           - current PC, byte address
//            busy         - executing (not IDLE/HALT)
//            halted       - in HALT
//            err          - HALT was reached through a fault
//            retire       - one-cycle pulse per completed instruction
//            retire_cnt   - instructions completed since the last start
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_cpu #(
   parameter int          IMEM_WORDS = 64,
   parameter int          DMEM_WORDS = 256,
   parameter int          MEM_WAIT   = 0,
   parameter logic [31:0] RF_INIT    = 32'd200,
   parameter logic [31:0] DMEM_INIT  = 32'd5
) (
   input  logic                          clk,
   input  logic                          Reset,
   input  logic                          start,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
   input  logic [31:0]                   imem_wdata,
   input  logic [4:0]                    dbg_reg_addr,
   output logic [31:0]                   dbg_reg_data,
   output logic [31:0]                   pc,
   output logic                          busy,
   output logic                          halted,
   output logic                          err,
   output logic                          retire,
   output logic [31:0]                   retire_cnt
);

   localparam int          IA         = $clog2(IMEM_WORDS);
   localparam int          DA         = $clog2(DMEM_WORDS);
   localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS) << 2;
   localparam logic [2:0]  WAIT_INIT  = 3'(MEM_WAIT);

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] FN_ADD = 6'd32;
   localparam logic [5:0] FN_SUB = 6'd34;
   localparam logic [5:0] FN_AND = 6'd36;
   localparam logic [5:0] FN_OR  = 6'd37;
   localparam logic [5:0] FN_SLT = 6'd42;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc4_q, pc4_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] imm_q, imm_d;
   logic [5:0]  op_q, op_d;
   logic [5:0]  funct_q, funct_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] mdr_q, mdr_d;
   logic [2:0]  wait_q, wait_d;
   logic        err_q, err_d;
   logic        retire_q, retire_d;
   logic [31:0] cnt_q, cnt_d;

   logic [31:0] imem_q [IMEM_WORDS];
   logic [31:0] dmem_q [DMEM_WORDS];
   logic [31:0] rf_q   [32];

   logic          w_busy;
   logic          w_im_we;
   logic          w_dm_we;
   logic [DA-1:0] w_dm_idx;
   logic          w_rf_we;
   logic [4:0]    w_rf_waddr;
   logic [31:0]   w_rf_wdata;
   logic          w_funct_ok;
   logic          w_taken;
   logic [IA-1:0] w_fetch_idx;

   assign w_busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
   assign w_im_we     = imem_we && !w_busy;
   assign w_dm_idx    = alu_q[DA+1:2];
   assign w_fetch_idx = pc_q[IA+1:2];
   assign w_funct_ok  = (funct_q == FN_ADD) || (funct_q == FN_SUB) || (funct_q == FN_AND) ||
                        (funct_q == FN_OR)  || (funct_q == FN_SLT);
   // bne takes the branch exactly when beq would not
   assign w_taken     = (a_q == b_q) != (op_q == OP_BNE);
   assign w_rf_waddr  = (op_q == OP_RTYPE) ? ir_q[15:11] : ir_q[20:16];
   assign w_rf_wdata  = (op_q == OP_LW) ? mdr_q : alu_q;

   assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'd0 : rf_q[dbg_reg_addr];
   assign pc           = pc_q;
   assign busy         = w_busy;
   assign halted       = (state_q == ST_HALT);
   assign err          = err_q;
   assign retire       = retire_q;
   assign retire_cnt   = cnt_q;

   // -------------------------------------------------------------------------
   // Next-state and datapath control
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pc4_d    = pc4_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      imm_d    = imm_q;
      op_d     = op_q;
      funct_d  = funct_q;
      alu_d    = alu_q;
      mdr_d    = mdr_q;
      wait_d   = wait_q;
      err_d    = err_q;
      retire_d = 1'b0;
      cnt_d    = cnt_q;
      w_dm_we  = 1'b0;
      w_rf_we  = 1'b0;

      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_d    = 32'd0;
               cnt_d   = 32'd0;
               err_d   = 1'b0;
            end
         end

         ST_FETCH: begin
            if (pc_q >= IMEM_BYTES) begin
               state_d = ST_HALT;
               err_d   = 1'b1;
            end else begin
               ir_d    = imem_q[w_fetch_idx];
               pc4_d   = pc_q + 32'd4;
               state_d = ST_DECODE;
            end
         end

         ST_DECODE: begin
            a_d     = rf_q[ir_q[25:21]];
            b_d     = rf_q[ir_q[20:16]];
            imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
            op_d    = ir_q[31:26];
            funct_d = ir_q[5:0];
            case (ir_q[31:26])
               OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: begin
                  state_d = ST_EXEC;
               end
               OP_HALT: begin
                  // halt retires but leaves pc on its own address
                  state_d  = ST_HALT;
                  retire_d = 1'b1;
                  cnt_d    = cnt_q + 32'd1;
               end
               default: begin
                  state_d = ST_HALT;
                  err_d   = 1'b1;
               end
            endcase
         end

         ST_EXEC: begin
            alu_d = a_q + imm_q;
            case (op_q)
               OP_RTYPE: begin
                  state_d = ST_WB;
                  case (funct_q)
                     FN_ADD:  alu_d = a_q + b_q;
                     FN_SUB:  alu_d = a_q - b_q;
                     FN_AND:  alu_d = a_q & b_q;
                     FN_OR:   alu_d = a_q | b_q;
                     FN_SLT:  alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
                     default: alu_d = 32'd0;
                  endcase
               end
               OP_ADDI: begin
                  state_d = ST_WB;
               end
               OP_LW, OP_SW: begin
                  state_d = ST_MEM;
                  wait_d  = WAIT_INIT;
               end
               OP_BEQ, OP_BNE: begin
                  pc_d     = w_taken ? (pc4_q + (imm_q << 2)) : pc4_q;
                  state_d  = ST_FETCH;
                  retire_d = 1'b1;
                  cnt_d    = cnt_q + 32'd1;
               end
               OP_J: begin
                  pc_d     = {pc4_q[31:28], ir_q[25:0], 2'b00};
                  state_d  = ST_FETCH;
                  retire_d = 1'b1;
                  cnt_d    = cnt_q + 32'd1;
               end
               default: begin
                  state_d = ST_HALT;
                  err_d   = 1'b1;
               end
            endcase
         end

         ST_MEM: begin
            // The access itself happens only on the last MEM cycle.
            if (wait_q != 3'd0) begin
               wait_d = wait_q - 3'd1;
            end else if (op_q == OP_LW) begin
               mdr_d   = dmem_q[w_dm_idx];
               state_d = ST_WB;
            end else begin
               w_dm_we  = 1'b1;
               pc_d     = pc4_q;
               state_d  = ST_FETCH;
               retire_d = 1'b1;
               cnt_d    = cnt_q + 32'd1;
            end
         end

         ST_WB: begin
            // Unsupported R-type functs are nops: they still retire.
            w_rf_we  = (op_q != OP_RTYPE) || w_funct_ok;
            pc_d     = pc4_q;
            state_d  = ST_FETCH;
            retire_d = 1'b1;
            cnt_d    = cnt_q + 32'd1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Control and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         pc_q     <= 32'd0;
         pc4_q    <= 32'd0;
         ir_q     <= 32'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         imm_q    <= 32'd0;
         op_q     <= 6'd0;
         funct_q  <= 6'd0;
         alu_q    <= 32'd0;
         mdr_q    <= 32'd0;
         wait_q   <= 3'd0;
         err_q    <= 1'b0;
         retire_q <= 1'b0;
         cnt_q    <= 32'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc4_q    <= pc4_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         imm_q    <= imm_d;
         op_q     <= op_d;
         funct_q  <= funct_d;
         alu_q    <= alu_d;
         mdr_q    <= mdr_d;
         wait_q   <= wait_d;
         err_q    <= err_d;
         retire_q <= retire_d;
         cnt_q    <= cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Storage: reset restores the fill values, so an aborted instruction can
   // never leave a partial write behind.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < IMEM_WORDS; i++) begin
            imem_q[i] <= 32'd0;
         end
      end else if (w_im_we) begin
         imem_q[imem_addr] <= imem_wdata;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DMEM_WORDS; i++) begin
            dmem_q[i] <= DMEM_INIT;
         end
      end else if (w_dm_we) begin
         dmem_q[w_dm_idx] <= b_q;
      end
   end

   // r0 is held at zero and never written.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         rf_q[0] <= 32'd0;
         for (int i = 1; i < 32; i++) begin
            rf_q[i] <= RF_INIT;
         end
      end else if (w_rf_we && (w_rf_waddr != 5'd0)) begin
         rf_q[w_rf_waddr] <= w_rf_wdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_cpu
// Purpose  : Self-checking bench for mips_multicycle_cpu. An instruction-level
//            interpreter predicts registers, data memory, final pc, retire
//            count, error flag and total cycle count for each program. The
//            programs are the directed cases plus randomly generated ones.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_cpu;

   localparam int IW = 16;
   localparam int DW = 16;
   localparam int MW = 2;

   logic        clk;
   logic        Reset;
   logic        start;
   logic        imem_we;
   logic [3:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [4:0]  dbg_reg_addr;
   logic [31:0] dbg_reg_data;
   logic [31:0] pc;
   logic        busy;
   logic        halted;
   logic        err;
   logic        retire;
   logic [31:0] retire_cnt;

   mips_multicycle_cpu #(
      .IMEM_WORDS (IW),
      .DMEM_WORDS (DW),
      .MEM_WAIT   (MW),
      .RF_INIT    (32'd200),
      .DMEM_INIT  (32'd5)
   ) u_dut (
      .clk          (clk),
      .Reset        (Reset),
      .start        (start),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .dbg_reg_addr (dbg_reg_addr),
      .dbg_reg_data (dbg_reg_data),
      .pc           (pc),
      .busy         (busy),
      .halted       (halted),
      .err          (err),
      .retire       (retire),
      .retire_cnt   (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // reference architectural state
   logic [31:0] m_rf [32];
   logic [31:0] m_dm [DW];
   logic [31:0] m_im [IW];
   logic [31:0] prog [IW];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(input int idx);
      return {6'd2, 26'(idx)};
   endfunction

   task automatic model_reset();
      m_rf[0] = 32'd0;
      for (int i = 1; i < 32; i++) m_rf[i] = 32'd200;
      for (int i = 0; i < DW; i++) m_dm[i] = 32'd5;
      for (int i = 0; i < IW; i++) m_im[i] = 32'd0;
   endtask

   // Instruction-level interpreter; cycle cost per instruction class.
   task automatic model_exec(output logic [31:0] o_pc, output logic [31:0] o_cnt,
                             output logic o_err, output int o_cyc);
      logic [31:0] p, ir, a, b, se, pc4, res, ad;
      logic [5:0]  op, fn;
      int          rs, rt, rd;
      bit          done, wr;
      p = 0; o_cnt = 0; o_err = 0; o_cyc = 0; done = 0;
      while (!done) begin
         if (p >= 32'(IW * 4)) begin
            o_err = 1; o_cyc += 1; done = 1;
         end else begin
            ir  = m_im[int'(p >> 2)];
            op  = ir[31:26];
            fn  = ir[5:0];
            rs  = int'(ir[25:21]);
            rt  = int'(ir[20:16]);
            rd  = int'(ir[15:11]);
            a   = m_rf[rs];
            b   = m_rf[rt];
            se  = {{16{ir[15]}}, ir[15:0]};
            pc4 = p + 4;
            ad  = a + se;
            case (op)
               6'd0: begin
                  wr = 1; res = 0;
                  case (fn)
                     6'd32:   res = a + b;
                     6'd34:   res = a - b;
                     6'd36:   res = a & b;
                     6'd37:   res = a | b;
                     6'd42:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                     default: wr = 0;
                  endcase
                  if (wr && rd != 0) m_rf[rd] = res;
                  o_cyc += 4; o_cnt++; p = pc4;
               end
               6'd8: begin
                  if (rt != 0) m_rf[rt] = ad;
                  o_cyc += 4; o_cnt++; p = pc4;
               end
               6'd35: begin
                  if (rt != 0) m_rf[rt] = m_dm[int'(ad[31:2]) % DW];
                  o_cyc += 5 + MW; o_cnt++; p = pc4;
               end
               6'd43: begin
                  m_dm[int'(ad[31:2]) % DW] = b;
                  o_cyc += 4 + MW; o_cnt++; p = pc4;
               end
               6'd4, 6'd5: begin
                  if ((a == b) == (op == 6'd4)) p = pc4 + (se << 2);
                  else p = pc4;
                  o_cyc += 3; o_cnt++;
               end
               6'd2: begin
                  p = {pc4[31:28], ir[25:0], 2'b00};
                  o_cyc += 3; o_cnt++;
               end
               6'h3F: begin
                  o_cyc += 2; o_cnt++; done = 1;
               end
               default: begin
                  o_cyc += 2; o_err = 1; done = 1;
               end
            endcase
         end
      end
      o_pc = p;
   endtask

   task automatic load_all();
      for (int i = 0; i < IW; i++) begin
         @(negedge clk);
         imem_we    = 1'b1;
         imem_addr  = 4'(i);
         imem_wdata = prog[i];
         m_im[i]    = prog[i];
         @(negedge clk);
         imem_we    = 1'b0;
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 32; i++) begin
         dbg_reg_addr = 5'(i);
         #1;
         check_eq($sformatf("%s r%0d", tag, i), dbg_reg_data, m_rf[i]);
      end
   endtask

   task automatic dbg_check(input string tag, input int idx, input logic [31:0] exp);
      dbg_reg_addr = 5'(idx);
      #1;
      check_eq(tag, dbg_reg_data, exp);
   endtask

   // poke_n: cycle at which start/imem_we are pulsed while busy (-1 = none);
   // wr0: write word 0 in the same cycle as start.
   task automatic run_prog(input string tag, input int poke_n, input logic [31:0] poke_data,
                           input bit wr0, input logic [31:0] wr0_data);
      logic [31:0] e_pc, e_cnt;
      logic        e_err;
      int          e_cyc, n, rets;
      if (wr0) m_im[0] = wr0_data;
      model_exec(e_pc, e_cnt, e_err, e_cyc);
      @(negedge clk);
      start = 1'b1;
      if (wr0) begin
         imem_we = 1'b1; imem_addr = 4'd0; imem_wdata = wr0_data;
      end
      @(posedge clk);
      #1;
      start = 1'b0; imem_we = 1'b0;
      n = 0; rets = 0;
      while (!halted && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
         if (retire) rets++;
         if (n == poke_n) begin
            start = 1'b1; imem_we = 1'b1; imem_addr = 4'd3; imem_wdata = poke_data;
         end else begin
            start = 1'b0; imem_we = 1'b0;
         end
      end
      start = 1'b0; imem_we = 1'b0;
      check_eq({tag, " cycles"}, 32'(n), 32'(e_cyc));
      check_eq({tag, " halted"}, {31'd0, halted}, 32'd1);
      check_eq({tag, " busy"}, {31'd0, busy}, 32'd0);
      check_eq({tag, " pc"}, pc, e_pc);
      check_eq({tag, " retire_cnt"}, retire_cnt, e_cnt);
      check_eq({tag, " retire pulses"}, 32'(rets), e_cnt);
      check_eq({tag, " err"}, {31'd0, err}, {31'd0, e_err});
      check_regs(tag);
   endtask

   task automatic gen_random_prog();
      int k, rs, rt, rd, fsel;
      logic [5:0] fns [8];
      fns[0] = 6'd32; fns[1] = 6'd34; fns[2] = 6'd36; fns[3] = 6'd37;
      fns[4] = 6'd42; fns[5] = 6'd0;  fns[6] = 6'd33; fns[7] = 6'd39;
      for (int i = 0; i < IW; i++) begin
         k    = int'($urandom_range(0, 15));
         rs   = int'($urandom_range(0, 7));
         rt   = int'($urandom_range(0, 7));
         rd   = int'($urandom_range(0, 7));
         fsel = int'($urandom_range(0, 7));
         case (k)
            0, 1, 2, 3: prog[i] = enc_r(rs, rt, rd, int'(fns[fsel]));
            4, 5, 6:    prog[i] = enc_i(8, rs, rt, int'($urandom));
            7:          prog[i] = enc_i(35, rs, rt, int'($urandom));
            8:          prog[i] = enc_i(43, rs, rt, int'($urandom));
            9:          prog[i] = enc_i(4, rs, rt, int'($urandom_range(0, IW - 1 - i)));
            10:         prog[i] = enc_i(5, rs, rt, int'($urandom_range(0, IW - 1 - i)));
            11:         prog[i] = enc_j(int'($urandom_range(i + 1, IW)));
            12:         prog[i] = 32'hFC00_0000;
            13:         prog[i] = ($urandom_range(0, 1) == 0) ? 32'hF800_0000 : 32'h0400_0000;
            default:    prog[i] = enc_i(8, rs, rt, int'($urandom_range(0, 40)));
         endcase
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < IW; i++) prog[i] = 32'd0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      Reset = 1'b1; start = 1'b0; imem_we = 1'b0; imem_addr = '0;
      imem_wdata = '0; dbg_reg_addr = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      Reset = 1'b0;
      #1;
      check_eq("rst busy", {31'd0, busy}, 32'd0);
      check_eq("rst halted", {31'd0, halted}, 32'd0);
      check_eq("rst err", {31'd0, err}, 32'd0);
      check_eq("rst retire", {31'd0, retire}, 32'd0);
      check_eq("rst retire_cnt", retire_cnt, 32'd0);
      check_eq("rst pc", pc, 32'd0);
      dbg_check("rst r0", 0, 32'd0);
      dbg_check("rst r10", 10, 32'd200);

      // arithmetic and signed compare
      clear_prog();
      prog[0] = enc_i(8, 0, 8, -4);
      prog[1] = enc_r(8, 8, 9, 32);
      prog[2] = enc_r(8, 0, 10, 42);
      prog[3] = 32'hFC00_0000;
      load_all();
      run_prog("alu", -1, 0, 0, 0);
      dbg_check("alu r9 const", 9, 32'hFFFF_FFF8);
      dbg_check("alu r10 const", 10, 32'd1);

      // store then load with wait states
      clear_prog();
      prog[0] = enc_i(8, 0, 8, 77);
      prog[1] = enc_i(43, 0, 8, 8);
      prog[2] = enc_i(35, 0, 11, 8);
      prog[3] = 32'hFC00_0000;
      load_all();
      run_prog("mem", -1, 0, 0, 0);
      dbg_check("mem r11 const", 11, 32'd77);

      // branches
      clear_prog();
      prog[0] = enc_i(4, 0, 0, 1);
      prog[1] = enc_i(8, 0, 12, 1);
      prog[2] = enc_i(5, 0, 0, 1);
      prog[3] = 32'hFC00_0000;
      load_all();
      run_prog("br", -1, 0, 0, 0);
      dbg_check("br r12 const", 12, 32'd200);
      check_eq("br pc const", pc, 32'h0000_000C);

      // illegal opcode
      clear_prog();
      prog[0] = enc_i(8, 0, 1, 1);
      prog[1] = enc_i(8, 0, 2, 2);
      prog[2] = 32'hF800_0000;
      load_all();
      run_prog("badop", -1, 0, 0, 0);
      check_eq("badop pc const", pc, 32'd8);

      // jump past the end of instruction memory
      clear_prog();
      prog[0] = enc_i(8, 0, 1, 3);
      prog[1] = enc_j(IW);
      load_all();
      run_prog("runoff", -1, 0, 0, 0);

      // r0 stays zero
      clear_prog();
      prog[0] = enc_i(8, 0, 0, 5);
      prog[1] = 32'hFC00_0000;
      load_all();
      run_prog("r0", -1, 0, 0, 0);

      // start and imem_we while busy are ignored
      clear_prog();
      prog[0] = enc_i(8, 0, 1, 1);
      prog[1] = enc_i(8, 1, 1, 1);
      prog[2] = enc_i(8, 1, 1, 1);
      prog[3] = 32'hFC00_0000;
      load_all();
      run_prog("busy poke", 2, 32'hF800_0000, 0, 0);

      // start and imem_we in the same idle cycle
      run_prog("start+we", -1, 0, 1, enc_i(8, 0, 13, 33));

      // reset in the middle of a lw MEM state
      clear_prog();
      prog[0] = enc_i(8, 0, 8, 9);
      prog[1] = enc_i(43, 0, 8, 0);
      prog[2] = 32'hFC00_0000;
      load_all();
      run_prog("pre-rst", -1, 0, 0, 0);
      clear_prog();
      prog[0] = 32'd0;
      prog[1] = enc_i(35, 0, 10, 0);
      prog[2] = 32'hFC00_0000;
      load_all();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check_eq("midrst busy before", {31'd0, busy}, 32'd1);
      check_eq("midrst pc before", pc, 32'd4);
      Reset = 1'b1;
      #1;
      check_eq("midrst busy", {31'd0, busy}, 32'd0);
      check_eq("midrst pc", pc, 32'd0);
      check_eq("midrst halted", {31'd0, halted}, 32'd0);
      check_eq("midrst retire_cnt", retire_cnt, 32'd0);
      dbg_check("midrst r10", 10, 32'd200);
      dbg_check("midrst r8", 8, 32'd200);
      @(negedge clk);
      Reset = 1'b0;
      model_reset();
      clear_prog();
      prog[0] = enc_i(35, 0, 10, 0);
      prog[1] = enc_i(35, 0, 11, 4);
      prog[2] = 32'hFC00_0000;
      load_all();
      run_prog("post-rst", -1, 0, 0, 0);
      dbg_check("post-rst r10 const", 10, 32'd5);

      // random programs
      for (int t = 0; t < 25; t++) begin
         gen_random_prog();
         load_all();
         run_prog($sformatf("rnd%0d", t), -1, 0, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
